// File: rtl/rip_axi_slave_mem_if.sv
// rip_axi_interface: five-channel AXI4 bundle shared by
// rip_axi_master and rip_axi_slave_mem.
interface rip_axi_interface #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0]     AWID;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [7:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;
  logic [ID_WIDTH-1:0]     BID;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ID_WIDTH-1:0]     ARID;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [7:0]              ARLEN;
  logic [2:0]              ARSIZE;
  logic [1:0]              ARBURST;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [ID_WIDTH-1:0]     RID;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RLAST;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/rip_axi_slave_mem.sv
// AXI4 slave backed by a dual-port word RAM.
// Define RIP_AXI_SLAVE_MEM_DECERR_EN to flag out-of-range bursts.
module rip_axi_slave_mem #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 1024
) (
  input logic clk,
  input logic rstn,
  rip_axi_interface.slave S_AXI
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int IW    = $clog2(MEM_WORDS);
  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic                  live;
  w_state_t              w_q, w_d;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_cnt;
  logic [1:0]            w_burst;
  logic                  w_err, w_dec;
  r_state_t              r_q, r_d;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len, r_cnt;
  logic [1:0]            r_burst;
  logic                  r_dec, r_first;
  logic [DATA_WIDTH-1:0] r_data;
  logic aw_hs, w_hs, w_last, aw_oor;
  logic ar_hs, r_hs, r_last, ar_oor;
  logic [IW-1:0] w_idx, r_idx;
  logic unused_bits;

`ifdef RIP_AXI_SLAVE_MEM_DECERR_EN
  assign aw_oor = (S_AXI.AWADDR >> (OFF + IW)) != '0;
  assign ar_oor = (S_AXI.ARADDR >> (OFF + IW)) != '0;
`else
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
`endif

  assign unused_bits = ^{S_AXI.AWSIZE, S_AXI.ARSIZE, w_addr, r_addr};

  assign w_idx  = w_addr[OFF +: IW];
  assign r_idx  = r_addr[OFF +: IW];
  assign w_last = w_cnt == w_len;
  assign r_last = r_cnt == r_len;
  assign aw_hs  = (w_q == W_IDLE) & live & S_AXI.AWVALID;
  assign w_hs   = (w_q == W_DATA) & S_AXI.WVALID;
  assign ar_hs  = (r_q == R_IDLE) & live & S_AXI.ARVALID;
  assign r_hs   = (r_q == R_DATA) & S_AXI.RREADY;

  assign S_AXI.BID   = w_id;
  assign S_AXI.BRESP = w_dec ? DECERR : (w_err ? SLVERR : OKAY);
  assign S_AXI.RID   = r_id;
  assign S_AXI.RDATA = r_data;
  assign S_AXI.RRESP = r_dec ? DECERR : OKAY;

  // Keeps ready low for the first cycle out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      live <= 1'b0;
      w_q  <= W_IDLE;
      r_q  <= R_IDLE;
    end else begin
      live <= 1'b1;
      w_q  <= w_d;
      r_q  <= r_d;
    end
  end

  always_comb begin
    w_d           = w_q;
    S_AXI.AWREADY = 1'b0;
    S_AXI.WREADY  = 1'b0;
    S_AXI.BVALID  = 1'b0;
    unique case (w_q)
      W_IDLE: begin
        S_AXI.AWREADY = live;
        if (aw_hs) w_d = W_DATA;
      end
      W_DATA: begin
        S_AXI.WREADY = 1'b1;
        if (w_hs && w_last) w_d = W_RESP;
      end
      W_RESP: begin
        S_AXI.BVALID = 1'b1;
        if (S_AXI.BREADY) w_d = W_IDLE;
      end
      default: w_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_d           = r_q;
    S_AXI.ARREADY = 1'b0;
    S_AXI.RVALID  = 1'b0;
    S_AXI.RLAST   = 1'b0;
    unique case (r_q)
      R_IDLE: begin
        S_AXI.ARREADY = live;
        if (ar_hs) r_d = R_FETCH;
      end
      R_FETCH: begin
        if (!r_first) r_d = R_DATA;
      end
      R_DATA: begin
        S_AXI.RVALID = 1'b1;
        S_AXI.RLAST  = r_last;
        if (S_AXI.RREADY) r_d = r_last ? R_IDLE : R_FETCH;
      end
      default: r_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
      w_dec   <= 1'b0;
    end else if (aw_hs) begin
      w_id    <= S_AXI.AWID;
      w_addr  <= S_AXI.AWADDR;
      w_len   <= S_AXI.AWLEN;
      w_cnt   <= '0;
      w_burst <= S_AXI.AWBURST;
      w_err   <= 1'b0;
      w_dec   <= aw_oor;
    end else if (w_hs) begin
      w_cnt <= w_cnt + 8'd1;
      w_err <= w_err | (S_AXI.WLAST != w_last);
      if (w_burst != FIXED)
        w_addr <= w_addr + ADDR_WIDTH'(BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && !w_dec) begin
      for (int i = 0; i < BYTES; i++)
        if (S_AXI.WSTRB[i])
          mem[w_idx][i*8 +: 8] <= S_AXI.WDATA[i*8 +: 8];
    end
  end

  // First beat spends one extra fetch cycle for address setup.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_burst <= '0;
      r_dec   <= 1'b0;
      r_first <= 1'b0;
      r_data  <= '0;
    end else if (ar_hs) begin
      r_id    <= S_AXI.ARID;
      r_addr  <= S_AXI.ARADDR;
      r_len   <= S_AXI.ARLEN;
      r_cnt   <= '0;
      r_burst <= S_AXI.ARBURST;
      r_dec   <= ar_oor;
      r_first <= 1'b1;
    end else if (r_q == R_FETCH) begin
      r_first <= 1'b0;
      if (!r_first)
        r_data <= r_dec ? '0 : mem[r_idx];
    end else if (r_hs) begin
      r_cnt <= r_cnt + 8'd1;
      if (r_burst != FIXED)
        r_addr <= r_addr + ADDR_WIDTH'(BYTES);
    end
  end
endmodule

// File: tb/tb_rip_axi_slave_mem.sv
// Directed bench for rip_axi_slave_mem: vector table
// plus burst, backpressure, protocol and reset sequences.
module tb_rip_axi_slave_mem;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] wdat [256];
  logic [31:0] rexp [256];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  id;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [9];
  int nv;

  rip_axi_interface #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  rip_axi_slave_mem #(
    .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(1024)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .S_AXI(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got %h expected %h", nm, what, act, exp);
    end
  endtask

  task automatic wbeat(input logic [31:0] d, input logic [3:0] s,
                       input logic l);
    int n = 0;
    bus.WDATA = d; bus.WSTRB = s; bus.WLAST = l; bus.WVALID = 1'b1;
    while (!bus.WREADY && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
  endtask

  task automatic wr(input logic [3:0] id, input logic [31:0] addr,
                    input logic [7:0] len, input logic [1:0] burst,
                    input logic [3:0] strb, input int last_at,
                    input logic [1:0] eresp, input string nm);
    int n = 0;
    bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len;
    bus.AWBURST = burst; bus.AWSIZE = 3'd2; bus.AWVALID = 1'b1;
    while (!bus.AWREADY && n < 50) begin @(negedge clk); n++; end
    chk(nm, "awready", bus.AWREADY, 1);
    @(negedge clk);
    bus.AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++)
      wbeat(wdat[i], strb, i == last_at);
    n = 0;
    while (!bus.BVALID && n < 50) begin @(negedge clk); n++; end
    chk(nm, "bvalid", bus.BVALID, 1);
    chk(nm, "bid", bus.BID, id);
    chk(nm, "bresp", bus.BRESP, eresp);
    bus.BREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0;
  endtask

  task automatic rd(input logic [3:0] id, input logic [31:0] addr,
                    input logic [7:0] len, input logic [1:0] burst,
                    input logic [1:0] eresp, input string nm);
    int n = 0;
    bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len;
    bus.ARBURST = burst; bus.ARSIZE = 3'd2; bus.ARVALID = 1'b1;
    while (!bus.ARREADY && n < 50) begin @(negedge clk); n++; end
    chk(nm, "arready", bus.ARREADY, 1);
    @(negedge clk);
    bus.ARVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!bus.RVALID && n < 50) begin @(negedge clk); n++; end
      if (b < 2) chk(nm, "latency", n, (b == 0) ? 2 : 1);
      chk(nm, "rdata", bus.RDATA, rexp[b]);
      chk(nm, "rlast", bus.RLAST, b == int'(len));
      chk(nm, "rresp", bus.RRESP, eresp);
      chk(nm, "rid", bus.RID, id);
      bus.RREADY = 1'b1;
      @(negedge clk);
      bus.RREADY = 1'b0;
    end
  endtask

  initial begin
    int n;
    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0;
    bus.AWBURST = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0;
    bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0;
    bus.ARBURST = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

    vt[0] = '{32'h10, 32'h00001234, 4'hf, 4'd3, 32'h00001234};
    vt[1] = '{32'h20, 32'hcafecafe, 4'hf, 4'd1, 32'hcafecafe};
    vt[2] = '{32'h20, 32'hbeefbeef, 4'h4, 4'd2, 32'hcaefcafe};
    vt[3] = '{32'h24, 32'hffffffff, 4'hf, 4'd4, 32'hffffffff};
    vt[4] = '{32'h24, 32'h11223344, 4'h9, 4'd5, 32'h11ffff44};
    vt[5] = '{32'h26, 32'ha5a5a5a5, 4'h2, 4'd6, 32'h11ffa544};
    vt[6] = '{32'h30, 32'h30303030, 4'hf, 4'd7, 32'h30303030};
    vt[7] = '{32'h54, 32'h54545454, 4'hf, 4'd8, 32'h54545454};
    nv = 8;
`ifndef RIP_AXI_SLAVE_MEM_DECERR_EN
    vt[8] = '{32'h1010, 32'h77777777, 4'hf, 4'd9, 32'h77777777};
    nv = 9;
`endif

    #1;
    chk("reset", "awready", bus.AWREADY, 0);
    chk("reset", "wready", bus.WREADY, 0);
    chk("reset", "bvalid", bus.BVALID, 0);
    chk("reset", "bid", bus.BID, 0);
    chk("reset", "bresp", bus.BRESP, 0);
    chk("reset", "arready", bus.ARREADY, 0);
    chk("reset", "rvalid", bus.RVALID, 0);
    chk("reset", "rlast", bus.RLAST, 0);
    chk("reset", "rid", bus.RID, 0);
    chk("reset", "rresp", bus.RRESP, 0);
    chk("reset", "rdata", bus.RDATA, 0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 256; i++) begin
      wdat[i] = {16'(i), ~16'(i)};
      rexp[i] = wdat[i];
    end
    wr(4'd2, 32'h0, 8'd255, INCR, 4'hf, 255, OKAY, "b256w");
    rd(4'd2, 32'h0, 8'd255, INCR, OKAY, "b256r");

    for (int i = 0; i < nv; i++) begin
      wdat[0] = vt[i].data;
      rexp[0] = vt[i].exp;
      wr(vt[i].id, vt[i].addr, 8'd0, INCR, vt[i].strb, 0, OKAY, "vecw");
      rd(vt[i].id, vt[i].addr, 8'd0, INCR, OKAY, "vecr");
    end

    wdat[0] = 32'h90abcdef; wdat[1] = 32'h12345678;
    rexp[0] = 32'h90abcdef; rexp[1] = 32'h12345678;
    wr(4'd3, 32'h10, 8'd1, INCR, 4'hf, 1, OKAY, "incr2w");
    rd(4'd3, 32'h10, 8'd1, INCR, OKAY, "incr2r");
    rd(4'd3, 32'h10, 8'd1, WRAP, OKAY, "wrap2r");
    rexp[0] = 32'h12345678;
    rd(4'd3, 32'h14, 8'd0, INCR, OKAY, "incr14");

    wdat[0] = 32'ha1a1a1a1; wdat[1] = 32'hb2b2b2b2;
    rexp[0] = 32'hb2b2b2b2; rexp[1] = 32'hb2b2b2b2;
    wr(4'd1, 32'h50, 8'd1, FIXED, 4'hf, 1, OKAY, "fixw");
    rd(4'd1, 32'h50, 8'd1, FIXED, OKAY, "fixr");
    rexp[0] = 32'h54545454;
    rd(4'd1, 32'h54, 8'd0, INCR, OKAY, "fixnb");

    for (int i = 0; i < 4; i++) begin
      wdat[i] = 32'h40404040 + 32'(i);
      rexp[i] = wdat[i];
    end
    wr(4'd5, 32'h40, 8'd3, INCR, 4'hf, 2, SLVERR, "earlylast");
    rd(4'd5, 32'h40, 8'd3, INCR, OKAY, "earlyrd");
    wdat[0] = 32'h60606060;
    wr(4'd6, 32'h60, 8'd0, INCR, 4'hf, -1, SLVERR, "nolast");

    bus.AWID = 4'ha; bus.AWADDR = 32'h38; bus.AWLEN = 8'd0;
    bus.AWBURST = INCR; bus.AWVALID = 1'b1;
    bus.ARID = 4'hb; bus.ARADDR = 32'h30; bus.ARLEN = 8'd0;
    bus.ARBURST = INCR; bus.ARVALID = 1'b1;
    chk("conc", "awready", bus.AWREADY, 1);
    chk("conc", "arready", bus.ARREADY, 1);
    @(negedge clk);
    bus.AWVALID = 1'b0; bus.ARVALID = 1'b0;
    wbeat(32'h38383838, 4'hf, 1'b1);
    n = 0;
    while (!bus.RVALID && n < 20) begin @(negedge clk); n++; end
    chk("conc", "rdata", bus.RDATA, 32'h30303030);
    chk("conc", "rid", bus.RID, 4'hb);
    chk("conc", "rlast", bus.RLAST, 1);
    chk("conc", "bvalid_early", bus.BVALID, 1);
    bus.RREADY = 1'b1;
    @(negedge clk);
    bus.RREADY = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("stall", "bvalid", bus.BVALID, 1);
      chk("stall", "bid", bus.BID, 4'ha);
      chk("stall", "awready", bus.AWREADY, 0);
      @(negedge clk);
    end
    bus.BREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0;
    chk("stall", "awready_after", bus.AWREADY, 1);
    chk("stall", "bvalid_after", bus.BVALID, 0);
    rexp[0] = 32'h38383838;
    rd(4'hc, 32'h38, 8'd0, INCR, OKAY, "conc38");

    bus.ARID = 4'h7; bus.ARADDR = 32'h40; bus.ARLEN = 8'd3;
    bus.ARBURST = INCR; bus.ARVALID = 1'b1;
    n = 0;
    while (!bus.ARREADY && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.ARVALID = 1'b0;
    n = 0;
    while (!bus.RVALID && n < 20) begin @(negedge clk); n++; end
    bus.RREADY = 1'b1;
    @(negedge clk);
    bus.RREADY = 1'b0;
    n = 0;
    while (!bus.RVALID && n < 20) begin @(negedge clk); n++; end
    chk("midrst", "beat2", bus.RDATA, 32'h40404041);
    rstn = 1'b0;
    #1;
    chk("midrst", "rvalid", bus.RVALID, 0);
    chk("midrst", "arready", bus.ARREADY, 0);
    chk("midrst", "awready", bus.AWREADY, 0);
    chk("midrst", "rdata", bus.RDATA, 0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    rexp[0] = 32'h90abcdef;
    rd(4'h1, 32'h10, 8'd0, INCR, OKAY, "postrst");

`ifdef RIP_AXI_SLAVE_MEM_DECERR_EN
    wdat[0] = 32'hdeaddead; wdat[1] = 32'hdeaddead;
    wr(4'd1, 32'h1000, 8'd1, INCR, 4'hf, 0, DECERR, "decw");
    rexp[0] = 32'h0; rexp[1] = 32'h0;
    rd(4'd1, 32'h1000, 8'd1, INCR, DECERR, "decr");
    rexp[0] = 32'h0000ffff;
    rd(4'd1, 32'h0, 8'd0, INCR, OKAY, "decnowrap");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rip_axi_slave_mem.md
Name: rip_axi_slave_mem

Overview:
- AXI4 full slave (responder) backed by an internal word-addressed RAM.
- It is the memory-side counterpart of rip_axi_master: it accepts the master's burst writes and reads on a rip_axi_interface slave modport.
- Used as a synthesizable on-chip data/instruction store and as a VIP-free bench target.
- Independent write and read FSMs; one outstanding transaction per direction.

Parameters:
ID_WIDTH, 4, AXI ID width (AWID/BID/ARID/RID).
ADDR_WIDTH, 32, AXI byte-address width.
DATA_WIDTH, 32, AXI data bus width in bits; multiple of 8.
MEM_WORDS, 1024, RAM depth in DATA_WIDTH words; power of two.

Ports:
clk  input  1  system clock; single clock domain.
rstn  input  1  asynchronous active-low reset.
S_AXI  interface  -  rip_axi_interface.slave modport, all five AXI4 channels, parameterised with ID_WIDTH/ADDR_WIDTH/DATA_WIDTH.

Behaviour:
- Reset values: AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=0, ARREADY=0, RVALID=0, RLAST=0, RID=0, RRESP=0, RDATA=0. Both FSMs go to IDLE. RAM contents are not cleared.
- Word index = (addr >> log2(DATA_WIDTH/8)) mod MEM_WORDS. Low address bits and AxSIZE are ignored; every beat is full width.
- Burst types: INCR and WRAP advance the address by DATA_WIDTH/8 per beat; WRAP is treated as INCR. FIXED holds the address.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY, latch AWID, AWADDR, AWLEN, AWBURST; clear beat count; go to W_DATA.
  - W_DATA: WREADY=1. Each WVALID&WREADY writes bytes where WSTRB[i]=1, then advances the address and count.
  - The burst ends at beat AWLEN+1 regardless of WLAST. If WLAST is not asserted exactly on that beat, the response is SLVERR(2'b10); otherwise OKAY.
  - W_RESP: BVALID=1, BID=latched ID. Hold until BREADY, then return to W_IDLE. AWREADY stays 0 until then.
- Read FSM R_IDLE -> R_FETCH -> R_DATA:
  - R_IDLE: ARREADY=1. On handshake, latch ARID, ARADDR, ARLEN, ARBURST.
  - R_FETCH: 1-cycle synchronous RAM read.
  - R_DATA: RVALID=1, RDATA=word, RID=latched ID, RRESP=OKAY, RLAST=1 on beat ARLEN+1. All held stable until RREADY.
  - After the RREADY handshake: go to R_IDLE if the beat was last, else to R_FETCH.
  - Latency: AR handshake at edge N gives RVALID high after edge N+2. Throughput is 1 beat per 2 cycles.
- Write and read paths run concurrently. RAM is true dual-port.
- Same-word read and write in the same cycle is read-first: the read returns the old data.
- A write-response stall (BREADY=0) never blocks reads, and vice versa.
- Reset asserted mid-burst aborts both channels immediately. All handshake outputs drop asynchronously. Partially written beats remain in RAM.
- AWLEN/ARLEN up to 255 (256 beats) are supported. The beat counter is 8 bits and must not wrap before the last beat.

Optional Feature:
RIP_AXI_SLAVE_MEM_DECERR_EN
- Defined: a burst whose start word index >= MEM_WORDS (before mod) is out of range.
  - Out-of-range writes consume all beats without touching RAM and respond BRESP=DECERR(2'b11).
  - Out-of-range reads return RDATA=0 with RRESP=DECERR on every beat. RLAST timing is unchanged.
  - DECERR takes precedence over the WLAST-mismatch SLVERR.
- Undefined: addresses wrap modulo MEM_WORDS and are never flagged.

Test Plan:
- Single beat: write 0x10 len0 data 0x00001234 strb 4'hF -> BRESP OKAY, BID echoes AWID=3. Read 0x10 -> RDATA 0x00001234, RLAST=1, RRESP OKAY, RVALID 2 cycles after the AR handshake.
- 2-beat INCR: write 0x10 {0x90abcdef, 0x12345678}, then read 0x10 len1 -> same two words in order, RLAST only on beat 2. Read 0x14 len0 -> 0x12345678.
- Byte strobes: preload 0x20 = 0xcafecafe, write 0xbeefbeef strb 4'b0100 -> read 0xcafecafe becomes 0xcaefcafe (only byte 2 changed).
- Concurrency/backpressure: issue write to 0x38 and read of 0x30 on the same cycle, holding BREADY=0 for 5 cycles -> read completes with correct data during the stall; BVALID held stable; next AWREADY only after B handshake.
- Protocol edge: 4-beat write with WLAST on beat 3 -> BRESP SLVERR, 4 beats written. 256-beat burst at 0x0 -> counter reaches 255, RLAST exactly on beat 256.
- Reset mid-read-burst (rstn=0 during beat 2 of 4) -> RVALID/ARREADY low at once; after release a new read of the earlier-written 0x10 returns the previously written data. With DECERR_EN, a read at word MEM_WORDS -> RDATA 0, RRESP 2'b11.
